control_sequencer: RTL
======================

# control_sequencer

Instruction sequencer for the relay computer: consumes the current instruction byte and ALU condition flags and drives every register load/select strobe, the ALU function code and memory read/write enables, one micro-step per clock. It is the direct producer of the control-signal bundle consumed by the register, program-control and bus blocks. Fetch, decode, execute and halt are handled by one Moore-style state machine.

## Interface
- No parameters.
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- run  in  1  leaves IDLE or HALT into FETCH0 when sampled high
- Inst  in  8  instruction register contents (valid from FETCH1 onward)
- aluZero, aluCarry, aluSign  in  1 each  ALU result flags
- LdA..LdY, LdJ1, LdJ2, LdInst, LdPC, LdINC, LdXY  out  1 each  register load strobes
- SelA..SelY, SelM, SelXY, SelJ, SelPC, SelINC, SelImm, SelAlu  out  1 each  bus drive selects
- AluFunctionCode  out  3  ALU operation; 0 outside ALU execute
- memRead, memWrite  out  1 each  memory strobes
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- States: IDLE, FETCH0, FETCH1, EXEC, G0–G5, INC0, INC1 (INC states only if the macro below is defined), HALT.
- Register codes: 0=A 1=B 2=C 3=D 4=M1 5=M2 6=X 7=Y. Within LOAD/STORE, rr selects A/B/C/D.
- FETCH0: SelPC, memRead, LdInst, LdINC. FETCH1: SelINC, LdPC. Next state is chosen from Inst.
- Single-step EXEC, then FETCH0:
  - MOV8 00dddsss: Sel<s>, Ld<d>. If d==s, no strobes are asserted.
  - SETAB 01rvvvvv: SelImm, LdA (r=0) or LdB (r=1).
  - ALU 1000rfff: AluFunctionCode=fff, SelAlu, LdA (r=0) or LdD (r=1). Internal flags zf/cf/sf are latched from the ALU flag inputs at the end of this cycle.
  - LOAD 100100rr: SelM, memRead, Ld<rr>.
  - STORE 100110rr: SelM, Sel<rr>, memWrite.
  - MOV16 10100dss: source s (00=M via SelM, 01=SelXY, 10=SelJ; 11 is illegal). Destination d (0=LdXY, 1=LdPC).
- GOTO 11dscznx:
  - G0: SelPC, memRead, LdJ1, LdINC. G1: SelINC, LdPC. G2: SelPC, memRead, LdJ2, LdINC. G3: SelINC, LdPC.
  - G4: if d, SelPC and LdXY (return address). Otherwise no strobes.
  - G5: if taken, SelJ and LdPC.
  - taken = (s&sf)|(c&cf)|(z&zf)|(n&~zf). When s, c, z and n are all 0, taken=1 (unconditional).
- HALT 10101110: enter HALT; halted=1; all strobes low. The machine stays in HALT until run=1, then goes to FETCH0.
- INCXY 10110000: INC0 (SelXY, LdINC), then INC1 (SelINC, LdXY), then FETCH0.
- Any other opcode: illegal=1 for one cycle in EXEC, no other strobes, then FETCH0.
- The ALU flags are not latched by any instruction other than ALU.

## Timing
- All outputs are decoded from the registered state plus Inst. No output depends combinationally on run or the ALU flags, except G5 LdPC/SelJ, which use the latched flags only.
- Reset values: state=IDLE, zf=cf=sf=0. Every output is 0, including halted, illegal and AluFunctionCode.
- Cycles per instruction, counted from FETCH0 to the next FETCH0:
  - MOV8, SETAB, ALU, LOAD, STORE, MOV16, illegal: 3
  - INCXY: 4
  - GOTO: 8
  - HALT: 2 cycles to reach the HALT state
- run is ignored outside IDLE and HALT.
- reset asserted in any state forces IDLE on the next edge, with all strobes low in that cycle. A partially executed instruction is abandoned.
- No two Sel strobes are ever high in the same cycle. Exception: STORE drives SelM (address bus) together with Sel<rr> (data bus).

## Configuration
- CONTROL_SEQUENCER_INCXY_EN defined: INCXY is decoded and executes through INC0/INC1.
- Not defined: the INC states are absent and 10110000 is treated as illegal (illegal pulse, 3-cycle NOP).

## Test plan
- reset held 2 cycles, then run=1 for one cycle -> FETCH0 follows. After reset, all outputs are 0.
- Inst=0x0A (MOV8 B<-C) -> FETCH0, FETCH1, then EXEC with SelC=1 and LdB=1 only. FETCH0 follows on the next cycle.
- Inst=0x85 (ALU r=0, f=5) with aluZero=1 -> EXEC shows AluFunctionCode=5, SelAlu, LdA. zf latched to 1.
- zf=1 and Inst=0xE4 (GOTO d=1, z=1):
  - G4 asserts SelPC and LdXY.
  - G5 asserts SelJ and LdPC.
  - With zf=0 instead, G5 shows no strobes.
- Inst=0xAE -> halted=1 from the third cycle and held across 10 cycles. run=1 returns to FETCH0 and halted=0.
- Inst=0xB0:
  - With the macro defined: INC0 (SelXY, LdINC), then INC1 (SelINC, LdXY).
  - Without the macro: illegal pulses once and no load strobes are asserted.
  - Separately, reset asserted during G2 -> IDLE with all strobes 0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute/halt micro-sequencer for the relay computer.
// Optional INCXY instruction is built when CONTROL_SEQUENCER_INCXY_EN is defined.
module control_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] Inst,
    input  logic       aluZero,
    input  logic       aluCarry,
    input  logic       aluSign,
    output logic       LdA,
    output logic       LdB,
    output logic       LdC,
    output logic       LdD,
    output logic       LdM1,
    output logic       LdM2,
    output logic       LdX,
    output logic       LdY,
    output logic       LdJ1,
    output logic       LdJ2,
    output logic       LdInst,
    output logic       LdPC,
    output logic       LdINC,
    output logic       LdXY,
    output logic       SelA,
    output logic       SelB,
    output logic       SelC,
    output logic       SelD,
    output logic       SelM1,
    output logic       SelM2,
    output logic       SelX,
    output logic       SelY,
    output logic       SelM,
    output logic       SelXY,
    output logic       SelJ,
    output logic       SelPC,
    output logic       SelINC,
    output logic       SelImm,
    output logic       SelAlu,
    output logic [2:0] AluFunctionCode,
    output logic       memRead,
    output logic       memWrite,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_EXEC,
        S_G0,
        S_G1,
        S_G2,
        S_G3,
        S_G4,
        S_G5,
`ifdef CONTROL_SEQUENCER_INCXY_EN
        S_INC0,
        S_INC1,
`endif
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic       zf_q, zf_d;
    logic       cf_q, cf_d;
    logic       sf_q, sf_d;
    logic [7:0] ld_r;
    logic [7:0] sel_r;

    logic is_mov8, is_setab, is_alu, is_load, is_store;
    logic is_mov16, is_goto, is_halt, is_incxy, taken;

    assign is_mov8  = (Inst[7:6] == 2'b00);
    assign is_setab = (Inst[7:6] == 2'b01);
    assign is_alu   = (Inst[7:4] == 4'b1000);
    assign is_load  = (Inst[7:2] == 6'b100100);
    assign is_store = (Inst[7:2] == 6'b100110);
    assign is_mov16 = (Inst[7:3] == 5'b10100) && (Inst[1:0] != 2'b11);
    assign is_goto  = (Inst[7:6] == 2'b11);
    assign is_halt  = (Inst == 8'hAE);
`ifdef CONTROL_SEQUENCER_INCXY_EN
    assign is_incxy = (Inst == 8'hB0);
`else
    assign is_incxy = 1'b0;
`endif

    // GOTO condition: any enabled latched flag, or unconditional when no bit set.
    assign taken = (Inst[4] & sf_q) | (Inst[3] & cf_q) |
                   (Inst[2] & zf_q) | (Inst[1] & ~zf_q) |
                   (Inst[4:1] == 4'b0000);

    assign {LdY, LdX, LdM2, LdM1, LdD, LdC, LdB, LdA}         = ld_r;
    assign {SelY, SelX, SelM2, SelM1, SelD, SelC, SelB, SelA} = sel_r;

    // State and flag registers; reset forces IDLE with flags cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            sf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            sf_q    <= sf_d;
        end
    end

    // Next-state selection and ALU flag capture.
    always_comb begin
        state_d = state_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        sf_d    = sf_q;
        unique case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH0;
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: begin
                if (is_goto)       state_d = S_G0;
                else if (is_halt)  state_d = S_HALT;
`ifdef CONTROL_SEQUENCER_INCXY_EN
                else if (is_incxy) state_d = S_INC0;
`endif
                else               state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH0;
                if (is_alu) begin
                    zf_d = aluZero;
                    cf_d = aluCarry;
                    sf_d = aluSign;
                end
            end
            S_G0: state_d = S_G1;
            S_G1: state_d = S_G2;
            S_G2: state_d = S_G3;
            S_G3: state_d = S_G4;
            S_G4: state_d = S_G5;
            S_G5: state_d = S_FETCH0;
`ifdef CONTROL_SEQUENCER_INCXY_EN
            S_INC0: state_d = S_INC1;
            S_INC1: state_d = S_FETCH0;
`endif
            S_HALT: if (run) state_d = S_FETCH0;
            default: state_d = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state and instruction byte.
    always_comb begin
        ld_r = '0;
        sel_r = '0;
        LdJ1 = 1'b0; LdJ2 = 1'b0; LdInst = 1'b0; LdPC = 1'b0;
        LdINC = 1'b0; LdXY = 1'b0;
        SelM = 1'b0; SelXY = 1'b0; SelJ = 1'b0; SelPC = 1'b0;
        SelINC = 1'b0; SelImm = 1'b0; SelAlu = 1'b0;
        AluFunctionCode = 3'd0;
        memRead = 1'b0; memWrite = 1'b0;
        halted = 1'b0; illegal = 1'b0;
        unique case (state_q)
            S_FETCH0: begin
                SelPC = 1'b1; memRead = 1'b1; LdInst = 1'b1; LdINC = 1'b1;
            end
            S_FETCH1, S_G1, S_G3: begin
                SelINC = 1'b1; LdPC = 1'b1;
            end
            S_EXEC: begin
                if (is_mov8) begin
                    if (Inst[5:3] != Inst[2:0]) begin
                        sel_r[Inst[2:0]] = 1'b1;
                        ld_r[Inst[5:3]]  = 1'b1;
                    end
                end else if (is_setab) begin
                    SelImm = 1'b1;
                    ld_r[{2'b00, Inst[5]}] = 1'b1;
                end else if (is_alu) begin
                    AluFunctionCode = Inst[2:0];
                    SelAlu = 1'b1;
                    if (Inst[3]) ld_r[3] = 1'b1;
                    else         ld_r[0] = 1'b1;
                end else if (is_load) begin
                    SelM = 1'b1; memRead = 1'b1;
                    ld_r[{1'b0, Inst[1:0]}] = 1'b1;
                end else if (is_store) begin
                    SelM = 1'b1; memWrite = 1'b1;
                    sel_r[{1'b0, Inst[1:0]}] = 1'b1;
                end else if (is_mov16) begin
                    SelM  = (Inst[1:0] == 2'b00);
                    SelXY = (Inst[1:0] == 2'b01);
                    SelJ  = (Inst[1:0] == 2'b10);
                    LdPC  = Inst[2];
                    LdXY  = ~Inst[2];
                end else begin
                    illegal = 1'b1;
                end
            end
            S_G0: begin
                SelPC = 1'b1; memRead = 1'b1; LdJ1 = 1'b1; LdINC = 1'b1;
            end
            S_G2: begin
                SelPC = 1'b1; memRead = 1'b1; LdJ2 = 1'b1; LdINC = 1'b1;
            end
            S_G4: begin
                SelPC = Inst[5]; LdXY = Inst[5];
            end
            S_G5: begin
                SelJ = taken; LdPC = taken;
            end
`ifdef CONTROL_SEQUENCER_INCXY_EN
            S_INC0: begin
                SelXY = 1'b1; LdINC = 1'b1;
            end
            S_INC1: begin
                SelINC = 1'b1; LdXY = 1'b1;
            end
`endif
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
